// File: rtl/pkt_mem_writer.sv
// Packet ring writer: streams header+payload flits into a RAM ring via port A, commits wr_ptr at packet ends.
// Latency: a flit accepted in cycle t is written (enable/write/address/data) in cycle t+1; done/drop pulses align with it.
// Backpressure: flit_ready_out is low when the ring is full (HEADER/PAYLOAD); DROP always accepts; never depends on valid.
// Ports:
//   clock, reset_n                     - rising-edge clock, async active-low reset
//   flit_valid_in/flit_data_in/ready   - upstream flit handshake; header bits[15:0] = payload length N
//   rd_ptr_in                          - consumer read offset, used only for the full check
//   mem_enable/write/address/data_out  - registered RAM port A write
//   wr_ptr_out                         - committed write offset (end of last complete packet)
//   pkt_done/start/len_out             - completion pulse plus header offset and length of that packet
//   pkt_drop_out                       - pulse when an oversize packet has been fully drained
module pkt_mem_writer #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int BASE_ADDR        = 0,
  parameter int BUFFER_WORDS     = 16
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              flit_valid_in,
  input  logic [MEMORY_BUS_WIDTH-1:0]       flit_data_in,
  output logic                              flit_ready_out,
  input  logic [$clog2(BUFFER_WORDS)-1:0]   rd_ptr_in,
  output logic                              mem_enable_out,
  output logic                              mem_write_out,
  output logic [MEMORY_BUS_WIDTH-3:0]       mem_address_out,
  output logic [MEMORY_BUS_WIDTH-1:0]       mem_data_out,
  output logic [$clog2(BUFFER_WORDS)-1:0]   wr_ptr_out,
  output logic                              pkt_done_out,
  output logic [$clog2(BUFFER_WORDS)-1:0]   pkt_start_out,
  output logic [15:0]                       pkt_len_out,
  output logic                              pkt_drop_out
);

  localparam int PW = $clog2(BUFFER_WORDS);
  localparam int AW = MEMORY_BUS_WIDTH - 2;
  localparam logic [AW-1:0] ADDR_BASE = AW'(BASE_ADDR);
  localparam logic [PW-1:0] LAST_SLOT = PW'(BUFFER_WORDS - 1);
  // Largest header+payload that fits, given one slot always stays empty.
  localparam logic [16:0]   MAX_PKT_WORDS = 17'(BUFFER_WORDS - 1);

  typedef enum logic [1:0] {ST_HEADER, ST_PAYLOAD, ST_DROP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] live_ptr_q;
  logic [15:0]   remaining_q;
  logic [PW-1:0] cur_start_q;
  logic [15:0]   cur_len_q;

  logic          full;
  logic          ready_int;
  logic          accept;
  logic [15:0]   hdr_len;
  logic          oversize;
  logic          write_flit;
  logic          last_word;
  logic          drop_last;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PW'(1);
  endfunction

  assign full     = (ptr_inc(live_ptr_q) == rd_ptr_in);
  assign hdr_len  = flit_data_in[15:0];
  assign oversize = ({1'b0, hdr_len} + 17'd1) > MAX_PKT_WORDS;
  // Reset forces ready low so every output reads 0 while reset_n is held.
  assign flit_ready_out = reset_n & ready_int;
  assign accept   = flit_valid_in & flit_ready_out;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_HEADER;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HEADER: begin
        if (accept) begin
          if (oversize)           state_d = ST_DROP;
          else if (hdr_len != '0) state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: if (accept && remaining_q == 16'd1) state_d = ST_HEADER;
      ST_DROP:    if (accept && remaining_q == 16'd1) state_d = ST_HEADER;
      default:    state_d = ST_HEADER;
    endcase
  end

  // Output / control decode
  always_comb begin
    ready_int  = 1'b0;
    write_flit = 1'b0;
    last_word  = 1'b0;
    drop_last  = 1'b0;
    case (state_q)
      ST_HEADER: begin
        ready_int  = !full;
        write_flit = accept && !oversize;
        last_word  = accept && !oversize && (hdr_len == '0);
      end
      ST_PAYLOAD: begin
        ready_int  = !full;
        write_flit = accept;
        last_word  = accept && (remaining_q == 16'd1);
      end
      ST_DROP: begin
        // Draining never touches the ring, so the full check does not apply.
        ready_int  = 1'b1;
        drop_last  = accept && (remaining_q == 16'd1);
      end
      default: ready_int = 1'b0;
    endcase
  end

  // Datapath: write port, pointers and packet bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      live_ptr_q      <= '0;
      remaining_q     <= '0;
      cur_start_q     <= '0;
      cur_len_q       <= '0;
      mem_enable_out  <= 1'b0;
      mem_write_out   <= 1'b0;
      mem_address_out <= '0;
      mem_data_out    <= '0;
      wr_ptr_out      <= '0;
      pkt_done_out    <= 1'b0;
      pkt_start_out   <= '0;
      pkt_len_out     <= '0;
      pkt_drop_out    <= 1'b0;
    end else begin
      mem_enable_out <= write_flit;
      mem_write_out  <= write_flit;
      pkt_done_out   <= last_word;
      pkt_drop_out   <= drop_last;

      if (write_flit) begin
        mem_address_out <= ADDR_BASE + AW'(live_ptr_q);
        mem_data_out    <= flit_data_in;
        live_ptr_q      <= ptr_inc(live_ptr_q);
      end

      if (accept && state_q == ST_HEADER) begin
        cur_start_q <= live_ptr_q;
        cur_len_q   <= hdr_len;
        remaining_q <= hdr_len;
      end else if (accept) begin
        remaining_q <= remaining_q - 16'd1;
      end

      // A header-only packet completes in the same cycle it is accepted,
      // so its start/len come straight from the header, not the saved copy.
      if (last_word) begin
        wr_ptr_out    <= ptr_inc(live_ptr_q);
        pkt_start_out <= (state_q == ST_HEADER) ? live_ptr_q : cur_start_q;
        pkt_len_out   <= (state_q == ST_HEADER) ? 16'd0 : cur_len_q;
      end
    end
  end

endmodule
